seg7_scan_driver: RTL and testbench

SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

---
 rtl/seg7_scan_driver.sv | 181 ++++++++++++++++++
 tb/tb_seg7_scan_driver.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
// Multiplexed seven-segment scan driver.
// Time-shares one segment bus across DIGITS anodes, blanks the anodes for a
// few cycles at each slot start, swaps in newly loaded contents only at frame
// boundaries, and adds per-digit blink plus leading-zero suppression.
module seg7_scan_driver #(
  parameter int DIGITS       = 8,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYC    = 4,
  parameter int BLINK_FRAMES = 250
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   data,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic [DIGITS-1:0]     en,
  input  logic [DIGITS-1:0]     blink,
  input  logic                  lz_blank,
  input  logic                  load,
  output logic [6:0]            hex,
  output logic                  DP,
  output logic [DIGITS-1:0]     AN,
  output logic                  frame_tick
);

  localparam int PW = $clog2(REFRESH_DIV);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [PW-1:0] P_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [PW-1:0] P_BLNK = PW'(BLANK_CYC);
  localparam logic [IW-1:0] I_LAST = IW'(DIGITS - 1);
  localparam logic [FW-1:0] F_LAST = FW'(BLINK_FRAMES - 1);

  // Active-low segment patterns {G,F,E,D,C,B,A} for a hex nibble.
  function automatic logic [6:0] seg_decode(input logic [3:0] n);
    case (n)
      4'h0: seg_decode = 7'b1000000;
      4'h1: seg_decode = 7'b1111001;
      4'h2: seg_decode = 7'b0100100;
      4'h3: seg_decode = 7'b0110000;
      4'h4: seg_decode = 7'b0011001;
      4'h5: seg_decode = 7'b0010010;
      4'h6: seg_decode = 7'b0000010;
      4'h7: seg_decode = 7'b1111000;
      4'h8: seg_decode = 7'b0000000;
      4'h9: seg_decode = 7'b0010000;
      4'hA: seg_decode = 7'b0001000;
      4'hB: seg_decode = 7'b0000011;
      4'hC: seg_decode = 7'b1000110;
      4'hD: seg_decode = 7'b0100001;
      4'hE: seg_decode = 7'b0000110;
      default: seg_decode = 7'b0001110;
    endcase
  endfunction

  logic [PW-1:0]       presc;
  logic [IW-1:0]       idx;
  logic [FW-1:0]       fcnt;
  logic                phase;
  logic                pend_flag;
  logic [4*DIGITS-1:0] pend_data, act_data;
  logic [DIGITS-1:0]   pend_dp, pend_en, pend_bl;
  logic [DIGITS-1:0]   act_dp, act_en, act_bl;

  logic slot_end, boundary;
  assign slot_end = (presc == P_LAST);
  assign boundary = slot_end && (idx == I_LAST);

  // Slot timing: prescaler, digit index, frame counter and blink phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc <= '0;
      idx   <= '0;
      fcnt  <= '0;
      phase <= 1'b0;
    end else begin
      presc <= slot_end ? '0 : presc + 1'b1;
      if (slot_end)
        idx <= (idx == I_LAST) ? '0 : idx + 1'b1;
      if (boundary) begin
        if (fcnt == F_LAST) begin
          fcnt  <= '0;
          phase <= ~phase;
        end else begin
          fcnt <= fcnt + 1'b1;
        end
      end
    end
  end

  // Double-buffered contents: loads park in pending, go live only at a boundary.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_flag <= 1'b0;
      pend_data <= '0;
      pend_dp   <= '0;
      pend_en   <= '0;
      pend_bl   <= '0;
      act_data  <= '0;
      act_dp    <= '0;
      act_en    <= '0;
      act_bl    <= '0;
    end else if (boundary) begin
      pend_flag <= 1'b0;
      if (load) begin
        act_data <= data;
        act_dp   <= dp_in;
        act_en   <= en;
        act_bl   <= blink;
      end else if (pend_flag) begin
        act_data <= pend_data;
        act_dp   <= pend_dp;
        act_en   <= pend_en;
        act_bl   <= pend_bl;
      end
    end else if (load) begin
      pend_flag <= 1'b1;
      pend_data <= data;
      pend_dp   <= dp_in;
      pend_en   <= en;
      pend_bl   <= blink;
    end
  end

  logic [3:0]        cur_nib;
  logic              cur_en, cur_dp, cur_bl, upper_zero;
  logic              lit, lz_sup, guard;
  logic [6:0]        hex_n;
  logic              dp_n;
  logic [DIGITS-1:0] an_n;

  // Per-slot segment/anode selection for the digit currently being scanned.
  always_comb begin
    cur_nib    = 4'h0;
    cur_en     = 1'b0;
    cur_dp     = 1'b0;
    cur_bl     = 1'b0;
    upper_zero = 1'b1;
    for (int j = 0; j < DIGITS; j++) begin
      if (j == int'(idx)) begin
        cur_nib = act_data[4*j +: 4];
        cur_en  = act_en[j];
        cur_dp  = act_dp[j];
        cur_bl  = act_bl[j];
      end
      // Disabled digits count as zero when looking for leading zeros.
      if (j >= int'(idx) && act_en[j] && act_data[4*j +: 4] != 4'h0)
        upper_zero = 1'b0;
    end
    lit    = cur_en && !(cur_bl && phase);
    lz_sup = lz_blank && (idx != '0) && upper_zero;
    guard  = (presc < P_BLNK);
    hex_n  = 7'h7F;
    dp_n   = 1'b1;
    an_n   = '1;
    if (lit) begin
      dp_n = ~cur_dp;
      if (!lz_sup)
        hex_n = seg_decode(cur_nib);
      // A suppressed zero still lights its anode when its point is wanted.
      if ((!lz_sup || cur_dp) && !guard)
        an_n = ~(DIGITS'(1) << idx);
    end
  end

  // Registered outputs, one cycle behind the scan state.
  always_ff @(posedge clk) begin
    if (rst) begin
      hex        <= 7'h7F;
      DP         <= 1'b1;
      AN         <= '1;
      frame_tick <= 1'b0;
    end else begin
      hex        <= hex_n;
      DP         <= dp_n;
      AN         <= an_n;
      frame_tick <= boundary;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver with a small 4-digit configuration.
module tb_seg7_scan_driver;

  localparam int D  = 4;
  localparam int RD = 8;
  localparam int BC = 2;
  localparam int BF = 2;

  logic          clk = 1'b0;
  logic          rst, lz_blank, load;
  logic [15:0]   data;
  logic [3:0]    dp_in, en, blink;
  logic [6:0]    hex;
  logic          DP;
  logic [3:0]    AN;
  logic          frame_tick;

  seg7_scan_driver #(.DIGITS(D), .REFRESH_DIV(RD), .BLANK_CYC(BC), .BLINK_FRAMES(BF)) dut (
    .clk(clk), .rst(rst), .data(data), .dp_in(dp_in), .en(en), .blink(blink),
    .lz_blank(lz_blank), .load(load), .hex(hex), .DP(DP), .AN(AN),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Expected {AN, hex, DP, frame_tick} per cycle.
  logic [12:0] sbq[$];
  logic [12:0] exp_v;

  // Reference state.
  int          m_cnt, m_idx, m_fc;
  bit          m_ph, p_flag;
  logic [15:0] a_data, p_data;
  logic [3:0]  a_en, a_dp, a_bl, p_en, p_dp, p_bl;

  logic [6:0] segtab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  function automatic logic [12:0] model_out();
    logic [3:0] an_e;
    logic [6:0] hx;
    logic       dpe, ft, lit, lz, zero;
    int         i;
    if (rst) return {4'hF, 7'h7F, 1'b1, 1'b0};
    i    = m_idx;
    ft   = (m_cnt == RD - 1) && (m_idx == D - 1);
    lit  = a_en[i] && !(a_bl[i] && m_ph);
    zero = 1'b1;
    for (int j = i; j < D; j++)
      if (a_en[j] && a_data[4*j +: 4] != 4'h0) zero = 1'b0;
    lz   = lz_blank && (i >= 1) && zero;
    an_e = 4'hF;
    hx   = 7'h7F;
    dpe  = 1'b1;
    if (lit) begin
      dpe = !a_dp[i];
      if (!lz) hx = segtab[a_data[4*i +: 4]];
      if ((!lz || a_dp[i]) && m_cnt >= BC) an_e[i] = 1'b0;
    end
    return {an_e, hx, dpe, ft};
  endfunction

  task automatic model_step();
    bit bd;
    if (rst) begin
      m_cnt = 0; m_idx = 0; m_fc = 0; m_ph = 0; p_flag = 0;
      a_data = '0; a_en = '0; a_dp = '0; a_bl = '0;
      p_data = '0; p_en = '0; p_dp = '0; p_bl = '0;
    end else begin
      bd = (m_cnt == RD - 1) && (m_idx == D - 1);
      if (bd) begin
        if (load) begin
          a_data = data; a_en = en; a_dp = dp_in; a_bl = blink;
        end else if (p_flag) begin
          a_data = p_data; a_en = p_en; a_dp = p_dp; a_bl = p_bl;
        end
        p_flag = 0;
        if (m_fc == BF - 1) begin m_fc = 0; m_ph = !m_ph; end
        else m_fc++;
      end else if (load) begin
        p_data = data; p_en = en; p_dp = dp_in; p_bl = blink; p_flag = 1;
      end
      if (m_cnt == RD - 1) begin m_cnt = 0; m_idx = (m_idx + 1) % D; end
      else m_cnt++;
    end
  endtask

  // One clock: predict, advance model, clock DUT, drop the load strobe.
  task automatic tick();
    sbq.push_back(model_out());
    model_step();
    @(posedge clk);
    #1;
    load = 1'b0;
    cyc++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (k == 3) rst = 1'b0;
      tick();
      exp_v = sbq.pop_front();
      n_cmp++;
      if ({AN, hex, DP, frame_tick} !== exp_v) begin
        n_bad++;
        $display("FAIL reset cyc=%0d got %b_%b_%b_%b required %b", cyc, AN, hex, DP, frame_tick, exp_v);
      end
    end
  endtask

  task automatic test_basic();
    logic [6:0] want [4] = '{7'b1000000, 7'b0001000, 7'b0100100, 7'b1111001};
    int last_ft = -1;
    int lows = 0;
    data = 16'h12A0; en = 4'hF; dp_in = 4'h0; blink = 4'h0; lz_blank = 1'b0;
    load = 1'b1;
    for (int k = 0; k < 104; k++) begin
      tick();
      exp_v = sbq.pop_front();
      n_cmp++;
      if ({AN, hex, DP, frame_tick} !== exp_v) begin
        n_bad++;
        $display("FAIL basic cyc=%0d got %b_%b_%b_%b required %b", cyc, AN, hex, DP, frame_tick, exp_v);
      end
      if (frame_tick === 1'b1) begin
        if (last_ft >= 0) begin
          n_cmp++;
          if (cyc - last_ft != 32) begin
            n_bad++;
            $display("FAIL tick_period got %0d required 32", cyc - last_ft);
          end
        end
        last_ft = cyc;
      end
      if (k >= 40 && AN !== 4'hF) begin
        lows++;
        for (int s = 0; s < 4; s++) begin
          if (AN === ~(4'b0001 << s)) begin
            n_cmp++;
            if (hex !== want[s] || DP !== 1'b1) begin
              n_bad++;
              $display("FAIL basic_digit%0d got hex=%b DP=%b required hex=%b DP=1", s, hex, DP, want[s]);
            end
          end
        end
      end
    end
    n_cmp++;
    if (lows != 48) begin
      n_bad++;
      $display("FAIL basic_an_low_cycles got %0d required 48", lows);
    end
  endtask

  task automatic test_lz();
    data = 16'h0005; en = 4'hF; dp_in = 4'b0100; blink = 4'h0; lz_blank = 1'b1;
    load = 1'b1;
    for (int k = 0; k < 72; k++) begin
      tick();
      exp_v = sbq.pop_front();
      n_cmp++;
      if ({AN, hex, DP, frame_tick} !== exp_v) begin
        n_bad++;
        $display("FAIL lz cyc=%0d got %b_%b_%b_%b required %b", cyc, AN, hex, DP, frame_tick, exp_v);
      end
      if (k >= 40 && AN !== 4'hF) begin
        n_cmp++;
        if (!((AN === 4'b1110 && hex === 7'b0010010 && DP === 1'b1) ||
              (AN === 4'b1011 && hex === 7'h7F && DP === 1'b0))) begin
          n_bad++;
          $display("FAIL lz_slot got AN=%b hex=%b DP=%b required 1110/0010010/1 or 1011/1111111/0", AN, hex, DP);
        end
      end
    end
    lz_blank = 1'b0;
  endtask

  task automatic test_blink();
    data = 16'h12A0; en = 4'hF; dp_in = 4'h0; blink = 4'b0001;
    load = 1'b1;
    for (int k = 0; k < 192; k++) begin
      tick();
      exp_v = sbq.pop_front();
      n_cmp++;
      if ({AN, hex, DP, frame_tick} !== exp_v) begin
        n_bad++;
        $display("FAIL blink cyc=%0d got %b_%b_%b_%b required %b", cyc, AN, hex, DP, frame_tick, exp_v);
      end
    end
    blink = 4'h0;
  endtask

  task automatic test_back_to_back();
    int guard_n;
    data = 16'h1111; en = 4'hF; dp_in = 4'h0; load = 1'b1;
    for (int k = 0; k < 48; k++) begin
      if (k == 4) begin data = 16'h2222; load = 1'b1; end
      tick();
      exp_v = sbq.pop_front();
      n_cmp++;
      if ({AN, hex, DP, frame_tick} !== exp_v) begin
        n_bad++;
        $display("FAIL b2b cyc=%0d got %b_%b_%b_%b required %b", cyc, AN, hex, DP, frame_tick, exp_v);
      end
    end
    guard_n = 0;
    while (!(m_cnt == RD - 1 && m_idx == D - 1) && guard_n < 64) begin
      tick();
      exp_v = sbq.pop_front();
      n_cmp++;
      if ({AN, hex, DP, frame_tick} !== exp_v) begin
        n_bad++;
        $display("FAIL b2b_wait cyc=%0d got %b_%b_%b_%b required %b", cyc, AN, hex, DP, frame_tick, exp_v);
      end
      guard_n++;
    end
    data = 16'h3C3C; load = 1'b1;
    for (int k = 0; k < 40; k++) begin
      tick();
      exp_v = sbq.pop_front();
      n_cmp++;
      if ({AN, hex, DP, frame_tick} !== exp_v) begin
        n_bad++;
        $display("FAIL b2b_boundary cyc=%0d got %b_%b_%b_%b required %b", cyc, AN, hex, DP, frame_tick, exp_v);
      end
    end
  endtask

  task automatic test_reset_mid();
    data = 16'h4567; en = 4'hF; load = 1'b1;
    for (int k = 0; k < 48; k++) begin
      if (k == 35) begin data = 16'h89AB; load = 1'b1; end
      rst = (k == 38);
      tick();
      exp_v = sbq.pop_front();
      n_cmp++;
      if ({AN, hex, DP, frame_tick} !== exp_v) begin
        n_bad++;
        $display("FAIL rstmid cyc=%0d got %b_%b_%b_%b required %b", cyc, AN, hex, DP, frame_tick, exp_v);
      end
      if (k >= 38) begin
        n_cmp++;
        if (AN !== 4'hF || hex !== 7'h7F || DP !== 1'b1) begin
          n_bad++;
          $display("FAIL rstmid_dark got AN=%b hex=%b DP=%b required 1111/1111111/1", AN, hex, DP);
        end
      end
    end
    for (int k = 0; k < 64; k++) begin
      if (k == 30) begin data = 16'h0F0F; load = 1'b1; end
      tick();
      exp_v = sbq.pop_front();
      n_cmp++;
      if ({AN, hex, DP, frame_tick} !== exp_v) begin
        n_bad++;
        $display("FAIL rstmid_reload cyc=%0d got %b_%b_%b_%b required %b", cyc, AN, hex, DP, frame_tick, exp_v);
      end
    end
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; lz_blank = 1'b0;
    data = '0; dp_in = '0; en = '0; blink = '0;
    m_cnt = 0; m_idx = 0; m_fc = 0; m_ph = 0; p_flag = 0;
    a_data = '0; a_en = '0; a_dp = '0; a_bl = '0;
    p_data = '0; p_en = '0; p_dp = '0; p_bl = '0;
    #1;
    test_reset();
    test_basic();
    test_lz();
    test_blink();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
